// File: rtl/grs_round_arbiter_pkg.sv
// Shared helpers for the rounding arbiter: index wrap and saturating statistics increment.
package grs_round_arbiter_pkg;

  localparam int STATS_W = 16;

  function automatic int wrap_add(input int a, input int b, input int n);
    int s;
    s = a + b;
    return (s >= n) ? s - n : s;
  endfunction

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v, input logic inc);
    return (inc && (v != '1)) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/grs_round.vh
// Shared rounding-mode codes for the GRS rounding datapath.
`ifndef GRS_ROUND_VH
`define GRS_ROUND_VH
`define GRS_MODE_W 3
`define GRS_RNE 3'd0
`define GRS_RTZ 3'd1
`define GRS_RNI 3'd2
`define GRS_RPI 3'd3
`define GRS_RNA 3'd4
`endif

// File: rtl/grs_rounder.sv
// Combinational guard/round/sticky rounder: truncates to OUTPUT_WIDTH and applies the mode's increment.
// Zero latency, no handshake; unknown mode codes truncate.
`include "grs_round.vh"

module grs_rounder #(
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 4
) (
  input  logic [INPUT_WIDTH-1:0]  value_in,
  input  logic                    sign_in,
  input  logic [`GRS_MODE_W-1:0]  mode_in,
  output logic [OUTPUT_WIDTH-1:0] value_out,
  output logic                    overflow_out
);
  localparam int DW = INPUT_WIDTH - OUTPUT_WIDTH;

  logic [OUTPUT_WIDTH-1:0] kept;
  logic [DW-1:0]           rem;
  logic [DW-1:0]           rem_lo;
  logic                    guard;
  logic                    sticky;
  logic                    inc;

  assign kept   = value_in[INPUT_WIDTH-1 -: OUTPUT_WIDTH];
  assign rem    = value_in[DW-1:0];
  // dropping the guard bit leaves exactly the round+sticky bits
  assign rem_lo = rem << 1;
  assign guard  = rem[DW-1];
  assign sticky = |rem_lo;

  always_comb begin
    inc = 1'b0;
    case (mode_in)
      `GRS_RNE: inc = guard & (sticky | kept[0]);
      `GRS_RTZ: inc = 1'b0;
      `GRS_RNI: inc = sign_in & (guard | sticky);
      `GRS_RPI: inc = ~sign_in & (guard | sticky);
      `GRS_RNA: inc = guard;
      default:  inc = 1'b0;
    endcase
  end

  assign {overflow_out, value_out} = {1'b0, kept} + {{OUTPUT_WIDTH{1'b0}}, inc};

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr; combinational grant, ptr updates on edge.
// Grants only while en is high; ptr moves past the winner only when a grant is made.
module rr_arbiter
  import grs_round_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic                 en,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    found   = 1'b0;
    gnt_idx = ptr;
    gnt     = '0;
    idx     = '0;
    for (int k = 0; k < N; k++) begin
      idx = IW'(wrap_add(int'(ptr), k, N));
      if (!found && req[idx]) begin
        found   = 1'b1;
        gnt_idx = idx;
      end
    end
    if (en && found) gnt[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (en && found) begin
      ptr <= IW'(wrap_add(int'(gnt_idx), 1, N));
    end
  end

endmodule

// File: rtl/grs_round_arbiter.sv
// Shares one grs_rounder among NUM_REQ requesters; 1-cycle latency, registered output, full throughput.
// Accepts only when the output slot is empty or draining; optional counters under GRS_ARB_STATS_EN.
`include "grs_round.vh"

module grs_round_arbiter
  import grs_round_arbiter_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int INPUT_WIDTH  = 8,
  parameter int OUTPUT_WIDTH = 4,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*INPUT_WIDTH-1:0] req_value,
  input  logic [NUM_REQ-1:0]             req_sign,
  input  logic [NUM_REQ*`GRS_MODE_W-1:0] req_mode,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUTPUT_WIDTH-1:0]        out_value,
  output logic                           out_overflow,
  output logic [ID_W-1:0]                out_id
`ifdef GRS_ARB_STATS_EN
  ,
  input  logic                           stats_clr,
  output logic [STATS_W-1:0]             stats_ops,
  output logic [STATS_W-1:0]             stats_ovf
`endif
);
  logic                    slot_free;
  logic                    accept;
  logic [NUM_REQ-1:0]      gnt;
  logic [ID_W-1:0]         gnt_idx;
  logic [INPUT_WIDTH-1:0]  sel_value;
  logic                    sel_sign;
  logic [`GRS_MODE_W-1:0]  sel_mode;
  logic [OUTPUT_WIDTH-1:0] rnd_value;
  logic                    rnd_ovf;

  assign slot_free = !out_valid || out_ready;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .en      (slot_free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;

  assign sel_value = req_value[gnt_idx*INPUT_WIDTH +: INPUT_WIDTH];
  assign sel_sign  = req_sign[gnt_idx];
  assign sel_mode  = req_mode[gnt_idx*`GRS_MODE_W +: `GRS_MODE_W];

  grs_rounder #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_rnd (
    .value_in     (sel_value),
    .sign_in      (sel_sign),
    .mode_in      (sel_mode),
    .value_out    (rnd_value),
    .overflow_out (rnd_ovf)
  );

  // a draining slot is refilled on the same edge, so no bubble between results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_value    <= '0;
      out_overflow <= 1'b0;
      out_id       <= '0;
    end else if (slot_free) begin
      out_valid <= accept;
      if (accept) begin
        out_value    <= rnd_value;
        out_overflow <= rnd_ovf;
        out_id       <= gnt_idx;
      end
    end
  end

`ifdef GRS_ARB_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stats_ops <= '0;
      stats_ovf <= '0;
    end else if (stats_clr) begin
      stats_ops <= '0;
      stats_ovf <= '0;
    end else begin
      stats_ops <= sat_inc(stats_ops, accept);
      stats_ovf <= sat_inc(stats_ovf, accept & rnd_ovf);
    end
  end
`endif

endmodule

// File: tb/tb_grs_round_arbiter.sv
// Randomised and directed bench for grs_round_arbiter with a queue scoreboard and arithmetic rounding model.
module tb_grs_round_arbiter;
  localparam int N   = 4;
  localparam int IW  = 8;
  localparam int OW  = 4;
  localparam int IDW = 2;
  localparam int RNE = 0, RTZ = 1, RNI = 2, RPI = 3, RNA = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N*IW-1:0] req_value;
  logic [N-1:0]    req_sign;
  logic [N*3-1:0]  req_mode;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_value;
  logic            out_overflow;
  logic [IDW-1:0]  out_id;
`ifdef GRS_ARB_STATS_EN
  logic            stats_clr;
  logic [15:0]     stats_ops;
  logic [15:0]     stats_ovf;
`endif

  grs_round_arbiter #(
    .NUM_REQ(N), .INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .ID_W(IDW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_value    (req_value),
    .req_sign     (req_sign),
    .req_mode     (req_mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_value    (out_value),
    .out_overflow (out_overflow),
    .out_id       (out_id)
`ifdef GRS_ARB_STATS_EN
    ,
    .stats_clr    (stats_clr),
    .stats_ops    (stats_ops),
    .stats_ovf    (stats_ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int val;
    bit ovf;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   v[N];
  int   val[N];
  bit   sg[N];
  int   md[N];
  bit   ordy;
  int   m_ptr = 0;
  bit   pushed_now = 1'b0;
  bit   mon_en = 1'b0;
  bit   g_found;
  int   g_idx;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Rounding from the numeric definition: integer quotient, remainder and half-ulp.
  function automatic void ref_round(input int v_in, input bit s, input int mode,
                                    output int res, output bit ovf);
    int sh, t, rem, half;
    bit up;
    sh   = IW - OW;
    t    = v_in >> sh;
    rem  = v_in % (1 << sh);
    half = 1 << (sh - 1);
    up   = 1'b0;
    case (mode)
      RNE:     up = (rem > half) || (rem == half && (t % 2) == 1);
      RTZ:     up = 1'b0;
      RNI:     up = s && (rem != 0);
      RPI:     up = !s && (rem != 0);
      RNA:     up = (rem >= half);
      default: up = 1'b0;
    endcase
    t   = t + (up ? 1 : 0);
    ovf = (t >= (1 << OW));
    res = t % (1 << OW);
  endfunction

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
  endtask

  task automatic set_req(input int i, input int value, input bit s, input int mode);
    v[i] = 1'b1; val[i] = value; sg[i] = s; md[i] = mode;
  endtask

  // One cycle: drive inputs after the falling edge, predict the grant, queue the expected result.
  task automatic step();
    exp_t         e;
    int           r, idx;
    bit           o;
    logic [N-1:0] exp_rdy;
    @(negedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      req_valid[i]          = v[i];
      req_value[i*IW +: IW] = val[i][IW-1:0];
      req_sign[i]           = sg[i];
      req_mode[i*3 +: 3]    = md[i][2:0];
    end
    out_ready = ordy;
    #1;
    g_found = 1'b0;
    g_idx   = 0;
    exp_rdy = '0;
    if (q.size() == 0 || ordy) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (!g_found && v[idx]) begin
          g_found = 1'b1;
          g_idx   = idx;
        end
      end
    end
    if (g_found) exp_rdy[g_idx] = 1'b1;
    check("req_ready", req_ready, exp_rdy);
    pushed_now = g_found;
    if (g_found) begin
      ref_round(val[g_idx], sg[g_idx], md[g_idx], r, o);
      e.id = g_idx; e.val = r; e.ovf = o;
      q.push_back(e);
      m_ptr = (g_idx + 1) % N;
    end
  endtask

  // Monitor: the queue head is whatever the output register should currently hold.
  initial begin
    bit ev;
    forever begin
      @(negedge clk);
      #3;
      if (mon_en && !rst) begin
        ev = (q.size() - (pushed_now ? 1 : 0)) > 0;
        check("out_valid", out_valid, ev);
        if (ev && out_valid) begin
          check("out_id", out_id, q[0].id);
          check("out_value", out_value, q[0].val);
          check("out_overflow", out_overflow, q[0].ovf);
        end
        if (ev && out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    clear_reqs();
    for (int i = 0; i < N; i++) begin
      val[i] = 0; sg[i] = 1'b0; md[i] = RNE;
    end
    ordy = 1'b1;
    req_valid = '0; req_value = '0; req_sign = '0; req_mode = '0; out_ready = 1'b0;
`ifdef GRS_ARB_STATS_EN
    stats_clr = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_value", out_value, 0);
    check("rst_out_overflow", out_overflow, 0);
    check("rst_out_id", out_id, 0);
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;

    // single request from requester 2
    set_req(2, 8'b0011_1000, 1'b0, RNE);
    step();
    check("single_ready", req_ready, 4'b0100);
    clear_reqs();
    step();
    check("single_valid", out_valid, 1);
    check("single_value", out_value, 4'b0100);
    check("single_ovf", out_overflow, 0);
    check("single_id", out_id, 2);

    // overflow out of the 4-bit result
    set_req(0, 8'hFF, 1'b0, RNE);
    step();
    clear_reqs();
    step();
    check("ovf_value", out_value, 0);
    check("ovf_flag", out_overflow, 1);
    check("ovf_id", out_id, 0);

    // backpressure with requester 1 waiting behind a held result
    set_req(3, 8'h5A, 1'b1, RNA);
    step();
    clear_reqs();
    set_req(1, 8'h27, 1'b0, RPI);
    ordy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      check("bp_ready", req_ready, 0);
      check("bp_id_hold", out_id, 3);
      check("bp_value_hold", out_value, 6);
    end
    ordy = 1'b1;
    step();
    check("bp_accept", req_ready, 4'b0010);
    clear_reqs();
    step();
    check("bp_id_after", out_id, 1);
    check("bp_value_after", out_value, 3);

    // reset while a result is held
    set_req(3, 8'h44, 1'b0, RTZ);
    step();
    clear_reqs();
    ordy = 1'b0;
    step();
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_mid_valid", out_valid, 0);
    q.delete();
    pushed_now = 1'b0;
    m_ptr = 0;
    mon_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    mon_en = 1'b1;
    ordy = 1'b1;

    // all requesters valid: grants rotate starting from 0
    for (int i = 0; i < N; i++) set_req(i, $urandom_range(0, 255), 1'($urandom_range(0, 1)), RNE);
    for (int k = 0; k <= 8; k++) begin
      step();
      if (k == 0) check("rr_first_grant", req_ready, 4'b0001);
      else begin
        check("rr_valid", out_valid, 1);
        check("rr_id", out_id, (k - 1) % N);
      end
    end

    // random traffic; waiting requesters keep their operands
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!(v[i] && !(g_found && g_idx == i))) begin
          v[i]   = 1'($urandom_range(0, 1));
          val[i] = $urandom_range(0, 255);
          sg[i]  = 1'($urandom_range(0, 1));
          md[i]  = $urandom_range(0, 4);
        end
      end
      ordy = ($urandom_range(0, 3) != 0);
      step();
    end
    clear_reqs();
    ordy = 1'b1;
    step();
    step();

`ifdef GRS_ARB_STATS_EN
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    begin
      int sv[5];
      sv = '{8'hFF, 8'h38, 8'hFF, 8'h10, 8'h21};
      for (int c = 0; c < 5; c++) begin
        clear_reqs();
        set_req(0, sv[c], 1'b0, RNE);
        step();
      end
    end
    clear_reqs();
    step();
    check("stats_ops", stats_ops, 5);
    check("stats_ovf", stats_ovf, 2);
    set_req(2, 8'hFF, 1'b0, RNE);
    stats_clr = 1'b1;
    step();
    stats_clr = 1'b0;
    clear_reqs();
    step();
    check("stats_ops_clr", stats_ops, 0);
    check("stats_ovf_clr", stats_ovf, 0);
`endif

    step();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
